// File: rtl/ctrl_out_logger.sv
// Change-event logger for the 20-bit controller output vector: timestamps each
// change with a saturating delta count and queues {delta, vec} in a small FIFO.
module ctrl_out_logger #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [19:0]    y_in,
  input  logic           clr_ovf,
  input  logic           ev_ready,
  output logic           ev_valid,
  output logic [DW+19:0] ev_data,
  output logic [2:0]     level,
  output logic           overflow
);

  typedef enum logic {WARM, RUN} state_t;

  state_t         state;
  logic [19:0]    prev;
  logic [DW-1:0]  cnt;
  logic [1:0]     wptr;
  logic [1:0]     rptr;
  logic [DW+19:0] mem [DEPTH];

  logic change;
  logic full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    ev_valid = (level != 3'd0);
    ev_data  = ev_valid ? mem[rptr] : '0;
    full     = (level == 3'(DEPTH));
    pop      = ev_valid && ev_ready;
    change   = en && (state == RUN) && (y_in != prev);
    // A full FIFO still accepts an event when the head leaves in the same cycle.
    push     = change && (!full || pop);
    drop     = change && full && !pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WARM;
      prev  <= '0;
      cnt   <= '0;
    end else if (en) begin
      if (state == WARM) begin
        state <= RUN;
        prev  <= y_in;
        cnt   <= '0;
      end else if (change) begin
        prev <= y_in;
        cnt  <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 2'd1;
      if (pop)  rptr <= rptr + 2'd1;
      if (push && !pop)      level <= level + 3'd1;
      else if (pop && !push) level <= level - 3'd1;
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Storage needs no reset: ev_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {cnt, y_in};
  end

endmodule

// File: tb/tb_ctrl_out_logger.sv
// Scoreboard bench for ctrl_out_logger: a behavioural queue model predicts the
// head entry, occupancy and overflow flag after every clock.
module tb_ctrl_out_logger;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [19:0] y_in;
  logic        clr_ovf;
  logic        ev_ready;
  logic        ev_valid;
  logic [27:0] ev_data;
  logic [2:0]  level;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [27:0] q[$];
  bit          m_run;
  logic [19:0] m_prev;
  logic [7:0]  m_cnt;
  bit          m_ovf;

  ctrl_out_logger #(.DEPTH(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .en(en), .y_in(y_in), .clr_ovf(clr_ovf),
    .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_data(ev_data),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] status();
    return {ev_valid, level, ev_data, overflow};
  endfunction

  function automatic logic [32:0] exp_status();
    logic [27:0] head;
    head = (q.size() != 0) ? q[0] : 28'h0;
    return {q.size() != 0, 3'(q.size()), head, m_ovf};
  endfunction

  task automatic model_reset();
    q.delete();
    m_run  = 0;
    m_prev = '0;
    m_cnt  = '0;
    m_ovf  = 0;
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic step(input logic [19:0] y, input bit e, input bit r, input bit c);
    bit pop, ch, drop;
    y_in = y; en = e; ev_ready = r; clr_ovf = c;
    pop  = (q.size() != 0) && r;
    ch   = e && m_run && (y != m_prev);
    drop = ch && (q.size() == 4) && !pop;
    if (pop) void'(q.pop_front());
    if (ch && !drop) q.push_back({m_cnt, y});
    if (drop) m_ovf = 1;
    else if (c) m_ovf = 0;
    if (e) begin
      if (!m_run) begin
        m_run = 1; m_prev = y; m_cnt = 0;
      end else if (ch) begin
        m_prev = y; m_cnt = 0;
      end else if (m_cnt != 8'hff) begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (status() !== 33'h0) begin
      n_err++; $display("FAIL reset_idle: got %h want 0", status());
    end
    en = 1; y_in = 20'hABCDE; ev_ready = 1;
    @(posedge clk); #1;
    n_vec++;
    if (status() !== 33'h0) begin
      n_err++; $display("FAIL reset_hold: got %h want 0", status());
    end
  endtask

  task automatic test_first_event();
    model_reset();
    y_in = 20'h0; en = 1; ev_ready = 0;
    rst = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      step(20'h00000, 1, 0, 0);
      n_vec++;
      if (ev_valid !== 1'b0 || status() !== exp_status()) begin
        n_err++; $display("FAIL first_quiet: got %h want %h", status(), exp_status());
      end
    end
    step(20'h40000, 1, 0, 0);
    n_vec++;
    if (ev_valid !== 1'b1 || ev_data !== 28'h0240000 || level !== 3'd1) begin
      n_err++; $display("FAIL first_event: got v=%b d=%h l=%0d want v=1 d=0240000 l=1",
                        ev_valid, ev_data, level);
    end
    step(20'h40000, 1, 1, 0);
    n_vec++;
    if (status() !== exp_status() || level !== 3'd0) begin
      n_err++; $display("FAIL first_pop: got %h want %h", status(), exp_status());
    end
  endtask

  task automatic test_saturate();
    for (int unsigned i = 0; i < 300; i++) step(20'h40000, 1, 0, 0);
    step(20'h00777, 1, 0, 0);
    n_vec++;
    if (ev_data !== {8'hff, 20'h00777} || status() !== exp_status()) begin
      n_err++; $display("FAIL saturate: got %h want %h", ev_data, {8'hff, 20'h00777});
    end
    step(20'h00777, 1, 1, 0);
  endtask

  task automatic test_overflow();
    logic [19:0] v [9];
    logic [19:0] tail [4];
    for (int unsigned i = 0; i < 9; i++) v[i] = 20'h10000 + 20'(i * 17 + 1);
    for (int unsigned i = 0; i < 6; i++) step(v[i], 1, 0, 0);
    n_vec++;
    if (level !== 3'd4 || overflow !== 1'b1 || ev_data[19:0] !== v[0]) begin
      n_err++; $display("FAIL overflow_fill: got l=%0d o=%b head=%h want l=4 o=1 head=%h",
                        level, overflow, ev_data[19:0], v[0]);
    end
    step(v[6], 1, 0, 1);
    n_vec++;
    if (overflow !== 1'b1 || status() !== exp_status()) begin
      n_err++; $display("FAIL set_beats_clr: got o=%b want 1", overflow);
    end
    step(v[6], 1, 0, 1);
    n_vec++;
    if (overflow !== 1'b0 || status() !== exp_status()) begin
      n_err++; $display("FAIL clr_ovf: got o=%b want 0", overflow);
    end
    step(v[7], 1, 1, 0);
    n_vec++;
    if (level !== 3'd4 || overflow !== 1'b0 || ev_data[19:0] !== v[1]) begin
      n_err++; $display("FAIL full_push_pop: got l=%0d o=%b head=%h want l=4 o=0 head=%h",
                        level, overflow, ev_data[19:0], v[1]);
    end
    tail[0] = v[1]; tail[1] = v[2]; tail[2] = v[3]; tail[3] = v[7];
    for (int unsigned i = 0; i < 4; i++) begin
      n_vec++;
      if (ev_valid !== 1'b1 || ev_data[19:0] !== tail[i] || status() !== exp_status()) begin
        n_err++; $display("FAIL order_%0d: got %h want vec %h", i, ev_data, tail[i]);
      end
      step(v[7], 1, 1, 0);
    end
    n_vec++;
    if (status() !== exp_status() || ev_data !== 28'h0) begin
      n_err++; $display("FAIL drained: got %h want %h", status(), exp_status());
    end
  endtask

  task automatic test_enable();
    step(20'h0A0A0, 1, 1, 0);
    for (int unsigned i = 0; i < 3; i++) step(20'h0A0A0, 1, 1, 0);
    for (int unsigned i = 0; i < 5; i++) begin
      step(20'h0F000 + 20'(i), 0, 1, 0);
      n_vec++;
      if (status() !== exp_status()) begin
        n_err++; $display("FAIL en_low_%0d: got %h want %h", i, status(), exp_status());
      end
    end
    step(20'h0A0A0, 1, 1, 0);
    step(20'h0B0B0, 1, 1, 0);
    n_vec++;
    if (ev_data !== {8'd4, 20'h0B0B0} || status() !== exp_status()) begin
      n_err++; $display("FAIL en_resume: got %h want %h", ev_data, {8'd4, 20'h0B0B0});
    end
    step(20'h0B0B0, 1, 1, 0);
  endtask

  task automatic test_reset_mid();
    step(20'h00001, 1, 0, 0);
    step(20'h00002, 1, 0, 0);
    step(20'h00003, 1, 0, 0);
    n_vec++;
    if (level !== 3'd3 || status() !== exp_status()) begin
      n_err++; $display("FAIL mid_fill: got l=%0d want 3", level);
    end
    #2 rst = 1;
    #1;
    model_reset();
    n_vec++;
    if (ev_valid !== 1'b0 || level !== 3'd0 || status() !== 33'h0) begin
      n_err++; $display("FAIL mid_reset: got %h want 0", status());
    end
    @(posedge clk); #1;
    rst = 0;
    step(20'h12345, 1, 1, 0);
    n_vec++;
    if (ev_valid !== 1'b0 || status() !== exp_status()) begin
      n_err++; $display("FAIL warm_after_rst: got %h want %h", status(), exp_status());
    end
    step(20'h54321, 1, 0, 0);
    n_vec++;
    if (ev_data !== {8'd0, 20'h54321} || status() !== exp_status()) begin
      n_err++; $display("FAIL run_after_rst: got %h want %h", status(), exp_status());
    end
  endtask

  task automatic test_back_to_back();
    for (int unsigned i = 0; i < 400; i++) begin
      step(20'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
      n_vec++;
      if (status() !== exp_status()) begin
        n_err++; $display("FAIL random_%0d: got %h want %h", i, status(), exp_status());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; en = 0; y_in = '0; clr_ovf = 0; ev_ready = 0;
    model_reset();
    test_reset();
    test_first_event();
    test_saturate();
    test_overflow();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_out_logger.md
CTRL_OUT_LOGGER -- requirements
Module: ctrl_out_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the event FIFO depth in entries; only the value 4 is supported.
REQ-002 SHALL have parameter DW, default 8, meaning the delta-timestamp width; only the value 8 is supported.
REQ-003 SHALL have port clk  input  1  system clock; all logic samples on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  sampling enable; when low, the block holds all state.
REQ-006 SHALL have port y_in  input  20  controller output vector y20..y1, with y1 at bit 0.
REQ-007 SHALL have port clr_ovf  input  1  synchronous one-cycle pulse that clears the overflow flag.
REQ-008 SHALL have port ev_ready  input  1  consumer accepts the head entry.
REQ-009 SHALL have port ev_valid  output  1  FIFO is not empty.
REQ-010 SHALL have port ev_data  output  28  head entry {delta[7:0], vec[19:0]}, shown ahead of the pop.
REQ-011 SHALL have port level  output  3  FIFO occupancy, 0..4.
REQ-012 SHALL have port overflow  output  1  sticky flag: an event was dropped.

Function
REQ-013 SHALL implement a two-state FSM with states WARM and RUN; reset enters WARM.
REQ-014 In WARM, the first cycle with en=1 SHALL load prev<=y_in, set cnt<=0, push nothing, and go to RUN.
REQ-015 In RUN, a cycle with en=1 and y_in!=prev SHALL raise a change event, record {cnt, y_in}, and set prev<=y_in and cnt<=0.
REQ-016 In RUN, a cycle with en=1 and y_in==prev SHALL set cnt<=min(cnt+1, 255), saturating with no wrap.
REQ-017 Any cycle with en=0 SHALL leave prev, cnt and the FSM unchanged and produce no event; pops still proceed.
REQ-018 pop SHALL equal ev_valid && ev_ready; on a pop, the head entry is removed at the rising edge.
REQ-019 An event SHALL be pushed if level<4, or if level==4 and a pop occurs in the same cycle; when full, the simultaneous push and pop leave level at 4.
REQ-020 An event arriving with level==4 and no pop SHALL be dropped and set overflow<=1; prev and cnt still update as in REQ-015.
REQ-021 When clr_ovf is asserted in the same cycle as a new drop, the set SHALL win and overflow is 1 afterwards.
REQ-022 The FIFO SHALL preserve event order; entries SHALL be stored with circular read and write pointers that wrap from 3 to 0.
REQ-023 ev_data SHALL be 0 whenever ev_valid=0.
REQ-024 Latency SHALL be one cycle from a y_in change to ev_valid, when the FIFO was empty.
REQ-025 ev_data and ev_valid SHALL be driven from registers with no combinational path from y_in; the only combinational path permitted is ev_ready to the pop decision.
REQ-026 ev_data SHALL remain stable while ev_valid=1 and ev_ready=0.

Reset
REQ-027 While rst=1, the block SHALL hold: FSM=WARM, prev=0, cnt=0, both pointers=0, level=0, ev_valid=0, ev_data=0, overflow=0.
REQ-028 Assertion of rst in mid-operation SHALL discard all FIFO contents immediately.
REQ-029 After rst is released, the next enabled cycle SHALL be a WARM baseline capture and SHALL produce no event.

Verification
REQ-030 Release reset with en=1, y_in=0x00000, then y_in=0x40000 three cycles later -> exactly one entry, {delta=2, vec=0x40000}, ev_valid high one cycle after the change.
REQ-031 Hold y_in constant for 300 enabled cycles, then change it -> delta=255 (saturated), with no wrap.
REQ-032 Hold ev_ready=0 and make 6 distinct changes -> level=4, overflow=1, and the FIFO holds the first 4 events in order.
REQ-033 Keep level=4 and ev_ready=1 while a new change arrives -> head popped, new event accepted, level stays 4, overflow stays 0.
REQ-034 Toggle en=0 for 5 cycles while y_in changes, then set en=1 -> changes during en=0 are ignored, and cnt resumes from its held value.
REQ-035 Assert rst with level=3 -> ev_valid=0 and level=0 at once; after release, the first enabled cycle produces no event.
